line_rasterizer: RTL and testbench
==================================

Name: line_rasterizer

Overview:
Bresenham line-drawing engine that sits directly upstream of the line drawer's AXI4 master write path (M00_AXI). It takes one line command (two endpoints and a colour), latched from the S00_AXI register file. It emits one pixel per cycle as a valid/ready stream of coordinates, framebuffer byte address and colour. The M00_AXI master consumes that stream and turns it into memory writes.

Parameters:
COORD_W, 11, width of the x/y coordinate fields
H_RES, 640, horizontal resolution; legal x is 0..H_RES-1
V_RES, 480, vertical resolution; legal y is 0..V_RES-1
STRIDE, 640, pixels per framebuffer row
ADDR_W, 32, width of the address fields

Ports:
ACLK  in  1  clock
ARESETN  in  1  synchronous active-low reset
cmd_valid  in  1  line command valid
cmd_ready  out  1  engine can accept a command
cmd_x0, cmd_y0  in  COORD_W  start point
cmd_x1, cmd_y1  in  COORD_W  end point
cmd_color  in  32  pixel colour
fb_base  in  ADDR_W  framebuffer base byte address, sampled at command accept
pix_valid  out  1  pixel output valid
pix_ready  in  1  downstream accepts the pixel
pix_x, pix_y  out  COORD_W  pixel coordinate
pix_addr  out  ADDR_W  fb_base + ((pix_y*STRIDE + pix_x) << 2)
pix_color  out  32  colour
pix_last  out  1  final pixel of the line
busy  out  1  high whenever state != IDLE
line_done  out  1  one-cycle pulse after the last pixel handshake
cmd_err  out  1  one-cycle pulse when an out-of-range command is dropped

Behaviour:
- Clock and reset: one clock, ACLK. ARESETN is synchronous and active-low.
- Reset: while ARESETN=0 at a rising edge, state=IDLE, and the following outputs are 0: pix_valid, pix_last, line_done, cmd_err, busy, pix_x, pix_y, pix_addr, pix_color. cmd_ready=0 while in reset and 1 in the first IDLE cycle after reset.
- Reset mid-line: abandons the line immediately. No line_done is issued and no further pixels are emitted.
- State IDLE: cmd_ready=1.
  - On cmd_valid, latch the endpoints, colour and fb_base.
  - If any coordinate is >= H_RES (x) or >= V_RES (y), pulse cmd_err next cycle and stay in IDLE.
  - Otherwise go to SETUP.
- State SETUP (1 cycle), cmd_ready=0. Compute:
  - dx = |x1-x0|, dy = -|y1-y0|
  - sx = +1 if x0<x1 else -1; sy = +1 if y0<y1 else -1
  - err = dx + dy
  - cur = (x0, y0)
  - All signed arithmetic is COORD_W+2 bits wide; no overflow is possible for legal inputs.
- State DRAW:
  - pix_valid=1. pix_x/pix_y = cur; pix_last = (cur == end).
  - All pix_* outputs are held stable while pix_valid && !pix_ready.
  - On handshake of a non-last pixel: e2 = 2*err.
    - If e2 >= dy: err += dy and x += sx.
    - If e2 <= dx: err += dx and y += sy.
    - Both tests use the pre-update err, and both updates apply in the same cycle (diagonal step).
  - On handshake with pix_last=1: go to DONE.
- State DONE (1 cycle): line_done=1, pix_valid=0, then go to IDLE.
- Latency and throughput:
  - Command accepted on edge T gives the first pix_valid after edge T+1.
  - One pixel per cycle while pix_ready=1.
  - Command-to-command minimum is N+3 cycles for an N-pixel line.
- Degenerate line (start == end): exactly one pixel, emitted with pix_last=1.
- Pixel count: exactly max(|dx|,|dy|)+1 pixels, in order from (x0,y0) to (x1,y1) inclusive. Endpoints are never swapped.
- pix_addr:
  - Derived from the registered cur and the latched base, with a constant multiply by STRIDE.
  - Valid in the same cycle as pix_valid; no added latency.
  - Wraps modulo 2^ADDR_W.
- pix_ready may be high while pix_valid=0 with no effect. pix_valid never drops without a handshake, except on reset.

Decomposition:
- Shared package line_raster_pkg:
  - COORD_W default constant
  - state enum {IDLE, SETUP, DRAW, DONE}
  - packed struct pixel_t {x, y, addr, color, last}
  - signed error type err_t (COORD_W+2 bits)
- Sub-module line_addr_gen: combinational address computation fb_base + ((y*STRIDE + x) << 2). It is shared with a future fill/clear engine.

Test Plan:
- Horizontal line (0,0)->(3,0), colour 0xFF00FF00, fb_base 0x1000_0000, pix_ready=1: pixels x=0..3, y=0, addrs 0x1000_0000/04/08/0C. pix_last only on x=3; line_done exactly one cycle later.
- Steep octant (2,1)->(4,6): exact sequence (2,1),(2,2),(3,3),(3,4),(4,5),(4,6); 6 pixels; pix_addr of (4,6) = base + (6*640+4)*4.
- Negative direction (5,5)->(0,3), random pix_ready stalls: sequence (5,5),(4,5),(3,4),(2,4),(1,3),(0,3). All pix_* stable across every stall cycle; no pixel lost or duplicated.
- Degenerate (7,7)->(7,7): one pixel with pix_last=1, then line_done. Out-of-range (640,0)->(1,1): no pix_valid, cmd_err pulses once, busy stays 0.
- ARESETN=0 after the 3rd pixel of (0,0)->(100,50): next cycle all outputs are 0 and no line_done. A subsequent command (0,0)->(1,1) emits (0,0),(1,1) correctly.
- Back-to-back: cmd_valid held high with two commands. The second is accepted only in the IDLE cycle after DONE; cmd_ready=0 throughout SETUP/DRAW/DONE.

Source files
------------

// File: rtl/line_raster_pkg.sv
// Shared types for the line rasterizer and its address generator.
// Struct and error widths follow the default coordinate and address widths.
package line_raster_pkg;

   localparam int unsigned DEF_COORD_W = 11;
   localparam int unsigned DEF_ADDR_W  = 32;

   typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;

   typedef struct packed {
      logic [DEF_COORD_W-1:0] x;
      logic [DEF_COORD_W-1:0] y;
      logic [DEF_ADDR_W-1:0]  addr;
      logic [31:0]            color;
      logic                   last;
   } pixel_t;

   // Two guard bits above the coordinate width keep 2*err in range.
   typedef logic signed [DEF_COORD_W+1:0] err_t;

endpackage

// File: rtl/line_addr_gen.sv
// Framebuffer byte address of a pixel: base + ((y*STRIDE + x) << 2), wrapping.
// Purely combinational so it can be shared with other pixel engines.
module line_addr_gen #(
   parameter int unsigned COORD_W = 11,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned STRIDE  = 640
) (
   input  logic [COORD_W-1:0] i_x,
   input  logic [COORD_W-1:0] i_y,
   input  logic [ADDR_W-1:0]  i_base,
   output logic [ADDR_W-1:0]  o_addr
);

   logic [ADDR_W-1:0] w_lin;

   assign w_lin  = ADDR_W'(i_y) * ADDR_W'(STRIDE) + ADDR_W'(i_x);
   assign o_addr = i_base + (w_lin << 2);

endmodule

// File: rtl/line_rasterizer.sv
// Bresenham line engine: accepts one line command, streams one pixel per cycle
// (coordinate, byte address, colour) on a valid/ready interface.
module line_rasterizer
   import line_raster_pkg::*;
#(
   parameter int unsigned COORD_W = DEF_COORD_W,
   parameter int unsigned H_RES   = 640,
   parameter int unsigned V_RES   = 480,
   parameter int unsigned STRIDE  = 640,
   parameter int unsigned ADDR_W  = DEF_ADDR_W
) (
   input  logic               ACLK,
   input  logic               ARESETN,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [COORD_W-1:0] cmd_x0,
   input  logic [COORD_W-1:0] cmd_y0,
   input  logic [COORD_W-1:0] cmd_x1,
   input  logic [COORD_W-1:0] cmd_y1,
   input  logic [31:0]        cmd_color,
   input  logic [ADDR_W-1:0]  fb_base,
   output logic               pix_valid,
   input  logic               pix_ready,
   output logic [COORD_W-1:0] pix_x,
   output logic [COORD_W-1:0] pix_y,
   output logic [ADDR_W-1:0]  pix_addr,
   output logic [31:0]        pix_color,
   output logic               pix_last,
   output logic               busy,
   output logic               line_done,
   output logic               cmd_err
);

   localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_RES - 1);
   localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_RES - 1);

   state_t r_state, w_state_d;

   logic [COORD_W-1:0] r_x0, r_y0, r_x1, r_y1;
   logic [COORD_W-1:0] r_cur_x, r_cur_y;
   logic [31:0]        r_color;
   logic [ADDR_W-1:0]  r_base;
   err_t               r_dx, r_dy, r_err;
   logic               r_sx_neg, r_sy_neg;
   logic               r_cmd_err;

   logic              w_accept, w_cmd_oor, w_last, w_step, w_step_x, w_step_y;
   err_t              w_xd, w_yd, w_dx, w_dy, w_e2, w_err_d;
   logic [ADDR_W-1:0] w_addr;
   pixel_t            w_pix;

   assign w_cmd_oor = (cmd_x0 > X_MAX) || (cmd_x1 > X_MAX) ||
                      (cmd_y0 > Y_MAX) || (cmd_y1 > Y_MAX);

   assign w_last = (r_state == DRAW) && (r_cur_x == r_x1) && (r_cur_y == r_y1);

   // Setup-cycle deltas; dy is kept negative as in the classic integer form.
   assign w_xd = err_t'({2'b00, r_x1}) - err_t'({2'b00, r_x0});
   assign w_yd = err_t'({2'b00, r_y1}) - err_t'({2'b00, r_y0});
   assign w_dx = w_xd[COORD_W+1] ? -w_xd : w_xd;
   assign w_dy = w_yd[COORD_W+1] ? w_yd : -w_yd;

   // Both step tests use the pre-update error so diagonal steps are one cycle.
   assign w_e2     = r_err <<< 1;
   assign w_step_x = (w_e2 >= r_dy);
   assign w_step_y = (w_e2 <= r_dx);
   assign w_err_d  = r_err + (w_step_x ? r_dy : '0) + (w_step_y ? r_dx : '0);

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      cmd_ready = 1'b0;
      pix_valid = 1'b0;
      line_done = 1'b0;
      w_accept  = 1'b0;
      case (r_state)
         IDLE: begin
            cmd_ready = ARESETN;
            w_accept  = cmd_valid && ARESETN;
            if (w_accept && !w_cmd_oor) begin
               w_state_d = SETUP;
            end
         end
         SETUP: w_state_d = DRAW;
         DRAW: begin
            pix_valid = 1'b1;
            if (pix_ready && w_last) begin
               w_state_d = DONE;
            end
         end
         DONE: begin
            line_done = 1'b1;
            w_state_d = IDLE;
         end
         default: w_state_d = IDLE;
      endcase
   end

   assign busy   = (r_state != IDLE);
   assign w_step = pix_valid && pix_ready && !w_last;

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         r_x0      <= '0;
         r_y0      <= '0;
         r_x1      <= '0;
         r_y1      <= '0;
         r_cur_x   <= '0;
         r_cur_y   <= '0;
         r_color   <= '0;
         r_base    <= '0;
         r_dx      <= '0;
         r_dy      <= '0;
         r_err     <= '0;
         r_sx_neg  <= 1'b0;
         r_sy_neg  <= 1'b0;
         r_cmd_err <= 1'b0;
      end else begin
         r_cmd_err <= w_accept && w_cmd_oor;
         if (w_accept) begin
            r_x0    <= cmd_x0;
            r_y0    <= cmd_y0;
            r_x1    <= cmd_x1;
            r_y1    <= cmd_y1;
            r_color <= cmd_color;
            r_base  <= fb_base;
         end
         if (r_state == SETUP) begin
            r_dx     <= w_dx;
            r_dy     <= w_dy;
            r_err    <= w_dx + w_dy;
            r_sx_neg <= !(r_x0 < r_x1);
            r_sy_neg <= !(r_y0 < r_y1);
            r_cur_x  <= r_x0;
            r_cur_y  <= r_y0;
         end
         if (w_step) begin
            r_err <= w_err_d;
            if (w_step_x) begin
               r_cur_x <= r_sx_neg ? r_cur_x - 1'b1 : r_cur_x + 1'b1;
            end
            if (w_step_y) begin
               r_cur_y <= r_sy_neg ? r_cur_y - 1'b1 : r_cur_y + 1'b1;
            end
         end
      end
   end

   line_addr_gen #(
      .COORD_W (COORD_W),
      .ADDR_W  (ADDR_W),
      .STRIDE  (STRIDE)
   ) u_addr_gen (
      .i_x    (r_cur_x),
      .i_y    (r_cur_y),
      .i_base (r_base),
      .o_addr (w_addr)
   );

   always_comb begin
      w_pix = '{x: r_cur_x, y: r_cur_y, addr: w_addr, color: r_color, last: w_last};
   end

   assign pix_x     = w_pix.x;
   assign pix_y     = w_pix.y;
   assign pix_addr  = w_pix.addr;
   assign pix_color = w_pix.color;
   assign pix_last  = w_pix.last;
   assign cmd_err   = r_cmd_err;

endmodule

// File: tb/tb_line_rasterizer.sv
// Self-checking bench for line_rasterizer: directed lines plus random lines
// compared against a queue-based Bresenham model of the pixel stream.
module tb_line_rasterizer;

   localparam int CW = 11;
   localparam int AW = 32;

   logic          ACLK = 1'b0;
   logic          ARESETN = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [CW-1:0] cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
   logic [31:0]   cmd_color = '0;
   logic [AW-1:0] fb_base = '0;
   logic          pix_valid;
   logic          pix_ready = 1'b1;
   logic [CW-1:0] pix_x, pix_y;
   logic [AW-1:0] pix_addr;
   logic [31:0]   pix_color;
   logic          pix_last, busy, line_done, cmd_err;

   always #5 ACLK = ~ACLK;

   line_rasterizer #(
      .COORD_W (CW),
      .H_RES   (640),
      .V_RES   (480),
      .STRIDE  (640),
      .ADDR_W  (AW)
   ) dut (
      .ACLK      (ACLK),
      .ARESETN   (ARESETN),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_x0    (cmd_x0),
      .cmd_y0    (cmd_y0),
      .cmd_x1    (cmd_x1),
      .cmd_y1    (cmd_y1),
      .cmd_color (cmd_color),
      .fb_base   (fb_base),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .pix_x     (pix_x),
      .pix_y     (pix_y),
      .pix_addr  (pix_addr),
      .pix_color (pix_color),
      .pix_last  (pix_last),
      .busy      (busy),
      .line_done (line_done),
      .cmd_err   (cmd_err)
   );

   typedef struct {
      int          x;
      int          y;
      logic [31:0] addr;
      logic [31:0] color;
      bit          last;
   } pix_t;
   typedef pix_t pix_q_t[$];

   int     n_checks = 0, n_fail = 0;
   int     cyc = 0;
   int     acc_n = 0, acc_cyc = 0, acc_hist[$];
   int     done_cnt = 0, err_cnt = 0, hs_cnt = 0, busy_cyc = 0, last_hs_cyc = 0;
   int     exp_lines = 0, exp_errs = 0;
   bit     stall_mode = 1'b0;
   pix_q_t exp_q;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference pixel sequence for a line, straight from the integer Bresenham rules.
   function automatic pix_q_t gen_line(int x0, int y0, int x1, int y1,
                                       logic [31:0] color, logic [31:0] base);
      pix_q_t q;
      int dx, dy, sx, sy, err, e2, x, y;
      pix_t p;
      dx  = (x1 > x0) ? x1 - x0 : x0 - x1;
      dy  = -((y1 > y0) ? y1 - y0 : y0 - y1);
      sx  = (x0 < x1) ? 1 : -1;
      sy  = (y0 < y1) ? 1 : -1;
      err = dx + dy;
      x   = x0;
      y   = y0;
      for (int k = 0; k < 4096; k++) begin
         p.x     = x;
         p.y     = y;
         p.addr  = base + 32'((y * 640 + x) * 4);
         p.color = color;
         p.last  = (x == x1) && (y == y1);
         q.push_back(p);
         if (p.last) break;
         e2 = 2 * err;
         if (e2 >= dy) begin err += dy; x += sx; end
         if (e2 <= dx) begin err += dx; y += sy; end
      end
      return q;
   endfunction

   always @(posedge ACLK) cyc <= cyc + 1;

   // Single compare process: observes every cycle on the falling edge.
   logic          prev_stall = 0, prev_valid = 0, prev_done = 0, prev_last = 0;
   logic [CW-1:0] prev_x, prev_y;
   logic [AW-1:0] prev_addr;
   logic [31:0]   prev_color;

   always @(negedge ACLK) begin : mon
      pix_t   e;
      pix_q_t q;
      if (ARESETN) begin
         chk("ready_vs_busy", cmd_ready, !busy);
         if (busy) busy_cyc++;
         if (prev_stall) begin
            chk("stall_valid", pix_valid, 1);
            chk("stall_x", pix_x, prev_x);
            chk("stall_y", pix_y, prev_y);
            chk("stall_addr", pix_addr, prev_addr);
            chk("stall_color", pix_color, prev_color);
            chk("stall_last", pix_last, prev_last);
         end
         if (pix_valid && !prev_valid) chk("first_pix_latency", cyc - acc_cyc, 2);
         if (pix_valid && pix_ready) begin
            chk("pixel_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("pix_x", pix_x, e.x);
               chk("pix_y", pix_y, e.y);
               chk("pix_addr", pix_addr, e.addr);
               chk("pix_color", pix_color, e.color);
               chk("pix_last", pix_last, e.last);
            end
            hs_cnt++;
            last_hs_cyc = cyc;
         end
         if (line_done) begin
            chk("done_timing", cyc, last_hs_cyc + 1);
            chk("done_queue_empty", exp_q.size(), 0);
            chk("done_single", prev_done, 0);
            done_cnt++;
         end
         if (cmd_err) err_cnt++;
         if (cmd_valid && cmd_ready) begin
            acc_n++;
            acc_hist.push_back(cyc);
            acc_cyc = cyc;
            if (cmd_x0 >= 640 || cmd_x1 >= 640 || cmd_y0 >= 480 || cmd_y1 >= 480) begin
               exp_errs++;
            end else begin
               q = gen_line(int'(cmd_x0), int'(cmd_y0), int'(cmd_x1), int'(cmd_y1),
                            cmd_color, fb_base);
               foreach (q[i]) exp_q.push_back(q[i]);
               exp_lines++;
            end
         end
         prev_stall = pix_valid && !pix_ready;
         prev_valid = pix_valid;
         prev_done  = line_done;
         prev_x     = pix_x;
         prev_y     = pix_y;
         prev_addr  = pix_addr;
         prev_color = pix_color;
         prev_last  = pix_last;
      end else begin
         prev_stall = 0;
         prev_valid = 0;
         prev_done  = 0;
      end
   end

   initial begin : ready_drv
      forever begin
         @(posedge ACLK);
         #1;
         pix_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic send(input int x0, input int y0, input int x1, input int y1,
                       input logic [31:0] col, input logic [31:0] base);
      int n0;
      bit ok;
      ok = 0;
      @(posedge ACLK);
      #1;
      cmd_x0 = CW'(x0); cmd_y0 = CW'(y0); cmd_x1 = CW'(x1); cmd_y1 = CW'(y1);
      cmd_color = col; fb_base = base; cmd_valid = 1'b1;
      n0 = acc_n;
      for (int i = 0; i < 3000; i++) begin
         @(posedge ACLK);
         if (acc_n != n0) begin ok = 1; break; end
      end
      #1 cmd_valid = 1'b0;
      chk("cmd_accepted", ok, 1);
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 0;
      for (int i = 0; i < 5000; i++) begin
         @(posedge ACLK);
         #1;
         if (!busy) begin ok = 1; break; end
      end
      chk("idle_timeout", ok, 1);
      repeat (2) @(posedge ACLK);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_pix_valid"}, pix_valid, 0);
      chk({tag, "_pix_last"}, pix_last, 0);
      chk({tag, "_line_done"}, line_done, 0);
      chk({tag, "_cmd_err"}, cmd_err, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_pix_x"}, pix_x, 0);
      chk({tag, "_pix_y"}, pix_y, 0);
      chk({tag, "_pix_addr"}, pix_addr, 0);
      chk({tag, "_pix_color"}, pix_color, 0);
      chk({tag, "_cmd_ready"}, cmd_ready, 0);
   endtask

   initial begin : main
      pix_q_t q;
      int     xs[6], ys[6];
      int     d0, e0, b0, h0, x0, y0, x1, y1, n;
      bit     hit;

      repeat (3) @(posedge ACLK);
      @(negedge ACLK);
      check_all_zero("reset");
      @(posedge ACLK);
      #1 ARESETN = 1'b1;
      @(negedge ACLK);
      chk("ready_after_reset", cmd_ready, 1);

      // Horizontal line
      q = gen_line(0, 0, 3, 0, 32'hFF00FF00, 32'h1000_0000);
      chk("model_h_len", q.size(), 4);
      chk("model_h_a0", q[0].addr, 32'h1000_0000);
      chk("model_h_a1", q[1].addr, 32'h1000_0004);
      chk("model_h_a3", q[3].addr, 32'h1000_000C);
      chk("model_h_last2", q[2].last, 0);
      chk("model_h_last3", q[3].last, 1);
      send(0, 0, 3, 0, 32'hFF00FF00, 32'h1000_0000);
      wait_idle();

      // Steep octant
      xs = '{2, 2, 3, 3, 4, 4};
      ys = '{1, 2, 3, 4, 5, 6};
      q = gen_line(2, 1, 4, 6, 32'h0000_00AA, 32'h2000_0000);
      chk("model_s_len", q.size(), 6);
      for (int i = 0; i < 6 && i < q.size(); i++) begin
         chk("model_s_x", q[i].x, xs[i]);
         chk("model_s_y", q[i].y, ys[i]);
      end
      chk("model_s_addr", q[5].addr, 32'h2000_3C10);
      send(2, 1, 4, 6, 32'h0000_00AA, 32'h2000_0000);
      wait_idle();

      // Negative direction with random stalls
      xs = '{5, 4, 3, 2, 1, 0};
      ys = '{5, 5, 4, 4, 3, 3};
      q = gen_line(5, 5, 0, 3, 32'h1234_5678, 32'h0000_0100);
      chk("model_n_len", q.size(), 6);
      for (int i = 0; i < 6 && i < q.size(); i++) begin
         chk("model_n_x", q[i].x, xs[i]);
         chk("model_n_y", q[i].y, ys[i]);
      end
      stall_mode = 1'b1;
      send(5, 5, 0, 3, 32'h1234_5678, 32'h0000_0100);
      wait_idle();
      stall_mode = 1'b0;

      // Degenerate line
      q = gen_line(7, 7, 7, 7, 32'hDEAD_BEEF, 32'h0);
      chk("model_d_len", q.size(), 1);
      chk("model_d_last", q[0].last, 1);
      d0 = done_cnt;
      send(7, 7, 7, 7, 32'hDEAD_BEEF, 32'h0);
      wait_idle();
      chk("degenerate_done", done_cnt - d0, 1);

      // Out-of-range command
      e0 = err_cnt; b0 = busy_cyc; h0 = hs_cnt;
      send(640, 0, 1, 1, 32'h5555_5555, 32'h0);
      wait_idle();
      chk("oor_err_pulses", err_cnt - e0, 1);
      chk("oor_no_busy", busy_cyc, b0);
      chk("oor_no_pixels", hs_cnt, h0);

      // Reset after the third pixel
      h0 = hs_cnt;
      send(0, 0, 100, 50, 32'h0F0F_0F0F, 32'h4000_0000);
      hit = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge ACLK);
         if (hs_cnt >= h0 + 3) begin hit = 1; break; end
      end
      chk("third_pixel_seen", hit, 1);
      #1 ARESETN = 1'b0;
      d0 = done_cnt;
      @(posedge ACLK);
      @(negedge ACLK);
      check_all_zero("midreset");
      exp_q.delete();
      exp_lines--;
      @(posedge ACLK);
      #1 ARESETN = 1'b1;
      repeat (4) @(posedge ACLK);
      chk("no_done_after_reset", done_cnt, d0);
      chk("no_pix_after_reset", hs_cnt, h0 + 3);
      send(0, 0, 1, 1, 32'hCAFE_F00D, 32'h0000_1000);
      wait_idle();

      // Back-to-back commands with cmd_valid held high
      @(posedge ACLK);
      #1;
      cmd_x0 = 0; cmd_y0 = 0; cmd_x1 = 3; cmd_y1 = 0;
      cmd_color = 32'hA5A5_A5A5; fb_base = 32'h0; cmd_valid = 1'b1;
      n = acc_n;
      for (int i = 0; i < 50 && acc_n == n; i++) @(posedge ACLK);
      #1;
      cmd_x0 = 1; cmd_y0 = 1; cmd_x1 = 2; cmd_y1 = 2; cmd_color = 32'h5A5A_5A5A;
      for (int i = 0; i < 50 && acc_n == n + 1; i++) @(posedge ACLK);
      #1 cmd_valid = 1'b0;
      chk("b2b_accepts", acc_n - n, 2);
      if (acc_hist.size() >= 2) begin
         chk("b2b_spacing", acc_hist[acc_hist.size() - 1] - acc_hist[acc_hist.size() - 2], 7);
      end
      wait_idle();

      // Randomised lines
      for (int t = 0; t < 25; t++) begin
         stall_mode = 1'($urandom_range(0, 1));
         x0 = $urandom_range(0, 639); x1 = $urandom_range(0, 639);
         y0 = $urandom_range(0, 479); y1 = $urandom_range(0, 479);
         if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 3))
               0: x0 = $urandom_range(640, 2047);
               1: x1 = $urandom_range(640, 2047);
               2: y0 = $urandom_range(480, 2047);
               default: y1 = $urandom_range(480, 2047);
            endcase
         end
         send(x0, y0, x1, y1, $urandom, $urandom);
         wait_idle();
      end
      stall_mode = 1'b0;

      chk("final_queue_empty", exp_q.size(), 0);
      chk("final_done_count", done_cnt, exp_lines);
      chk("final_err_count", err_cnt, exp_errs);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
